s_memory_reader: RTL
====================

S_MEMORY_READER -- requirements
Module: s_memory_reader

Interface
REQ-001 Parameter: RAM_WIDTH, default 8, data width and address width; RAM depth = 2^RAM_WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begins one full sweep when sampled high in IDLE.
REQ-005 ram_q  input  RAM_WIDTH  RAM read data, valid one cycle after address is presented.
REQ-006 address  output  RAM_WIDTH  RAM read address.
REQ-007 write_enable  output  1  RAM write strobe, constant 0.
REQ-008 out_data  output  RAM_WIDTH  byte read from RAM.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_last  output  1  high with out_valid for the final entry.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final handshake.
REQ-014 mismatch  output  1  sticky integrity flag; see Configuration.

Function
REQ-015 FSM states: IDLE, READ, CAPTURE, OUT, DONE.
REQ-016 IDLE: start=1 -> READ with index=0; start=0 -> stay in IDLE.
REQ-017 READ: address=index, then unconditionally -> CAPTURE.
REQ-018 CAPTURE: register ram_q into out_data, then -> OUT.
REQ-019 OUT: out_valid=1; out_data, address, and out_last held stable until out_ready=1.
REQ-020 OUT handshake with index=2^RAM_WIDTH-1 -> DONE; otherwise index+1 -> READ.
REQ-021 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-022 Index counts 0..2^RAM_WIDTH-1 with no wrap inside a sweep; index resets to 0 on entry to READ from IDLE.
REQ-023 out_last = out_valid and index==2^RAM_WIDTH-1.
REQ-024 Timing with out_ready tied high and start seen at edge 0: byte k is valid in cycle 3+3k; the last byte (k=255) is valid in cycle 768; done is high in cycle 769.
REQ-025 out_ready low stalls the block in OUT indefinitely with no data loss; out_ready is ignored outside OUT.
REQ-026 start is ignored while busy; start held high in DONE does not take effect until the cycle the FSM is in IDLE.
REQ-027 out_valid and done are never high in the same cycle.

Reset
REQ-028 reset=1 forces IDLE at the next edge and has priority over every other input, including mid-sweep and in the same cycle as start or a handshake.
REQ-029 Reset values: address=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, mismatch=0, index=0.
REQ-030 A sweep interrupted by reset does not resume; a new start is required.

Configuration
REQ-031 Macro: S_MEMORY_READER_CHECK_EN.
REQ-032 When defined: in CAPTURE, ram_q != index sets mismatch, which stays set until reset or until a new sweep starts from IDLE, where it clears.
REQ-033 When undefined: mismatch is tied to 0 and no comparator is built.
REQ-034 The macro does not change any other output or the timing of any other output.

Verification
REQ-035 RAM preloaded with S[i]=i, out_ready=1, start pulse -> 256 bytes 0x00..0xFF, byte k valid in cycle 3+3k, out_last only on 0xFF, done in cycle 769, mismatch=0.
REQ-036 out_ready low for 10 cycles during byte 0x40 -> out_valid stays high, out_data=0x40 stable, address=0x40 stable; the stream resumes with no gaps or duplicates.
REQ-037 CHECK_EN defined, RAM location 0x7A corrupted to 0x00 -> mismatch rises in the cycle after CAPTURE of index 0x7A, stays high through done, and clears on the next start.
REQ-038 reset asserted while in OUT for index 0x10 -> next cycle: IDLE, all outputs at reset values; a later start streams again from 0x00.
REQ-039 start held high continuously -> back-to-back sweeps separated by DONE plus one IDLE cycle; start pulses during a sweep do not restart or shorten it.

Source files
------------

// File: rtl/s_memory_reader.sv
// Sweeps a synchronous-read RAM from address 0 to the top and streams each entry
// over a valid/ready port. Optional ram_q==index integrity check: S_MEMORY_READER_CHECK_EN.
module s_memory_reader #(
  parameter int RAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RAM_WIDTH-1:0] ram_q,
  output logic [RAM_WIDTH-1:0] address,
  output logic                 write_enable,
  output logic [RAM_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch
);

  localparam logic [RAM_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    OUT,
    DONE
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [RAM_WIDTH-1:0] index;
  logic                 at_last;

  assign at_last = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = READ;
      READ:    next_state = CAPTURE;
      CAPTURE: next_state = OUT;
      OUT:     if (out_ready) next_state = at_last ? DONE : READ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // index doubles as the RAM address; it only moves on a handshake, so the
  // address stays stable while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
    end else begin
      unique case (state)
        IDLE:    if (start) index <= '0;
        OUT:     if (out_ready && !at_last) index <= index + 1'b1;
        DONE:    index <= '0;
        default: index <= index;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (state == CAPTURE) begin
      out_data <= ram_q;
    end
  end

`ifdef S_MEMORY_READER_CHECK_EN
  logic mismatch_r;

  // Sticky until reset or the start of the next sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_r <= 1'b0;
    end else if (state == IDLE && start) begin
      mismatch_r <= 1'b0;
    end else if (state == CAPTURE && ram_q != index) begin
      mismatch_r <= 1'b1;
    end
  end

  assign mismatch = mismatch_r;
`else
  assign mismatch = 1'b0;
`endif

  assign address      = index;
  assign write_enable = 1'b0;
  assign out_valid    = (state == OUT);
  assign out_last     = out_valid && at_last;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule
